// File: rtl/bcd_disp_mux_n.sv
// Display-mode mux that turns switches, BCD result, and blink/test timebase into per-digit SEG7_4 codes.
// One-cycle registered latency from inputs to dig; no handshake, inputs are sampled every cycle.
module bcd_disp_mux_n #(
    parameter int NDIG        = 4,
    parameter int RDIG        = 3,
    parameter int BLINK_TICKS = 250
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [9:0]          SW,
    input  logic [4*RDIG-1:0]   RSLT,
    input  logic [2:0]          out_mux_sel,
    input  logic                tick,
    input  logic                blink_en,
    output logic [5*NDIG-1:0]   dig,
    output logic                blink_phase
);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [4:0] UPCA = 5'h0A;
    localparam logic [4:0] UPCB = 5'h0B;
    localparam logic [4:0] UPCC = 5'h0C;
    localparam logic [4:0] UPCE = 5'h0E;
    localparam logic [4:0] SEGA = 5'd16;
    localparam logic [4:0] BLNK = 5'd23;
    localparam logic [4:0] LCR  = 5'd28;

    logic [2:0]            r_sel_q;
    logic [BW-1:0]         r_bcnt;
    logic                  r_blink_phase;
    logic [2:0]            r_seg_idx;
    logic [NDIG-1:0][4:0]  r_dig;

    logic [NDIG-1:0][4:0]  w_dig;
    logic [RDIG-1:0]       w_upper_nz;
    logic                  w_mode_chg;
    logic                  w_hide;
    logic                  w_unused_sw;

    assign w_mode_chg  = (out_mux_sel != r_sel_q);
    assign w_hide      = blink_en & r_blink_phase;
    assign w_unused_sw = &{1'b0, SW[9:8]};
    assign dig         = r_dig;
    assign blink_phase = r_blink_phase;

    // w_upper_nz[i] is set when any result digit from i upward is non-zero
    always_comb begin
        logic w_nz;
        w_nz       = 1'b0;
        w_upper_nz = '0;
        for (int i = RDIG - 1; i >= 0; i--) begin
            w_nz          = w_nz | (|RSLT[4*i +: 4]);
            w_upper_nz[i] = w_nz;
        end
    end

    always_comb begin
        for (int i = 0; i < NDIG; i++) w_dig[i] = BLNK;
        case (out_mux_sel)
            3'd0, 3'd1: begin
                w_dig[NDIG-1] = w_hide ? BLNK : ((out_mux_sel == 3'd0) ? UPCA : UPCB);
                w_dig[1]      = {1'b0, SW[7:4]};
                w_dig[0]      = {1'b0, SW[3:0]};
            end
            3'd2: begin
                w_dig[NDIG-1] = w_hide ? BLNK : UPCC;
                w_dig[0]      = {4'b0, SW[0]};
            end
            3'd3: begin
                for (int i = 0; i < RDIG; i++) begin
                    if (i == 0 || w_upper_nz[i]) w_dig[i] = {1'b0, RSLT[4*i +: 4]};
                end
            end
            3'd4: begin
                for (int i = 0; i < NDIG; i++) w_dig[i] = 5'h00;
            end
            3'd5: ;
            3'd6: begin
                w_dig[2] = UPCE;
                w_dig[1] = LCR;
                w_dig[0] = LCR;
            end
            default: begin
                for (int i = 0; i < NDIG; i++) w_dig[i] = SEGA + {2'b0, r_seg_idx};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dig         <= {NDIG{BLNK}};
            r_blink_phase <= 1'b0;
            r_bcnt        <= '0;
            r_seg_idx     <= 3'd0;
            r_sel_q       <= 3'd5;
        end else begin
            r_dig   <= w_dig;
            r_sel_q <= out_mux_sel;
            // A mode change restarts the blink timebase and beats any tick
            if (w_mode_chg) begin
                r_bcnt        <= '0;
                r_blink_phase <= 1'b0;
                if (out_mux_sel == 3'd7) r_seg_idx <= 3'd0;
            end else if (tick) begin
                if (r_bcnt == BW'(BLINK_TICKS - 1)) begin
                    r_bcnt        <= '0;
                    r_blink_phase <= ~r_blink_phase;
                    if (r_sel_q == 3'd7) r_seg_idx <= (r_seg_idx == 3'd6) ? 3'd0 : r_seg_idx + 3'd1;
                end else begin
                    r_bcnt <= r_bcnt + BW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_disp_mux_n.sv
// Directed bench for bcd_disp_mux_n with a per-cycle reference model and literal checkpoints.
module tb_bcd_disp_mux_n;
    logic        clk;
    logic        reset;
    logic [9:0]  SW;
    logic [11:0] RSLT;
    logic [2:0]  out_mux_sel;
    logic        tick;
    logic        blink_en;
    logic [19:0] dig;
    logic        blink_phase;

    int total = 0;
    int bad   = 0;

    bcd_disp_mux_n #(.NDIG(4), .RDIG(3), .BLINK_TICKS(2)) dut (
        .clk(clk), .reset(reset), .SW(SW), .RSLT(RSLT), .out_mux_sel(out_mux_sel),
        .tick(tick), .blink_en(blink_en), .dig(dig), .blink_phase(blink_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [19:0] pk(input int d3, input int d2, input int d1, input int d0);
        return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endfunction

    // Reference model: digit value straight from the display rules
    function automatic int exp_digit(input int pos, input int mode, input int sw, input int rslt,
                                     input bit ben, input int ph, input int seg);
        int v;
        case (mode)
            0, 1: begin
                if (pos == 3) return (ben && ph == 1) ? 23 : (mode == 0 ? 10 : 11);
                if (pos == 1) return (sw / 16) % 16;
                if (pos == 0) return sw % 16;
                return 23;
            end
            2: begin
                if (pos == 3) return (ben && ph == 1) ? 23 : 12;
                if (pos == 0) return sw % 2;
                return 23;
            end
            3: begin
                if (pos >= 3) return 23;
                v = rslt >> (4 * pos);
                if (pos > 0 && v == 0) return 23;
                return v % 16;
            end
            4: return 0;
            5: return 23;
            6: begin
                if (pos == 2) return 14;
                if (pos < 2) return 28;
                return 23;
            end
            default: return 16 + seg;
        endcase
    endfunction

    int m_dig[4];
    int m_ph, m_bcnt, m_seg, m_selq;
    bit m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 4; p++) m_dig[p] = 23;
            m_ph = 0; m_bcnt = 0; m_seg = 0; m_selq = 5; m_valid = 1;
        end else if (m_valid) begin
            for (int p = 0; p < 4; p++)
                m_dig[p] = exp_digit(p, int'(out_mux_sel), int'(SW), int'(RSLT), blink_en, m_ph, m_seg);
            if (int'(out_mux_sel) != m_selq) begin
                m_bcnt = 0; m_ph = 0;
                if (out_mux_sel == 3'd7) m_seg = 0;
            end else if (tick) begin
                m_bcnt = (m_bcnt + 1) % 2;
                if (m_bcnt == 0) begin
                    m_ph = 1 - m_ph;
                    if (out_mux_sel == 3'd7) m_seg = (m_seg + 1) % 7;
                end
            end
            m_selq = int'(out_mux_sel);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int p = 0; p < 4; p++) chk($sformatf("model_dig%0d", p), int'(dig[5*p +: 5]), m_dig[p]);
            chk("model_phase", int'(blink_phase), m_ph);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; SW = '0; RSLT = '0; out_mux_sel = 3'd5; tick = 1'b0; blink_en = 1'b0;
        cyc(2);
        chk("reset_dig", int'(dig), int'(pk(23, 23, 23, 23)));
        chk("reset_phase", int'(blink_phase), 0);

        reset = 1'b0; out_mux_sel = 3'd0; SW = 10'h047;
        cyc();
        chk("showa", int'(dig), int'(pk(10, 23, 4, 7)));

        blink_en = 1'b1; tick = 1'b1;
        cyc(2);
        chk("blink_phase_up", int'(blink_phase), 1);
        cyc();
        chk("blink_hidden", int'(dig[19:15]), 23);
        cyc(2);
        chk("blink_shown", int'(dig[19:15]), 10);
        cyc();
        out_mux_sel = 3'd1;
        cyc();
        chk("chg_clears_phase", int'(blink_phase), 0);
        cyc();
        chk("showb_prompt", int'(dig[19:15]), 11);
        tick = 1'b0; blink_en = 1'b0;

        out_mux_sel = 3'd2; SW = 10'h001;
        cyc();
        chk("showcin", int'(dig), int'(pk(12, 23, 23, 1)));

        out_mux_sel = 3'd3;
        RSLT = 12'h005; cyc(); chk("lz_005", int'(dig), int'(pk(23, 23, 23, 5)));
        RSLT = 12'h040; cyc(); chk("lz_040", int'(dig), int'(pk(23, 23, 4, 0)));
        RSLT = 12'h000; cyc(); chk("lz_000", int'(dig), int'(pk(23, 23, 23, 0)));
        RSLT = 12'h100; cyc(); chk("lz_100", int'(dig), int'(pk(23, 1, 0, 0)));
        RSLT = 12'h0A0; cyc(); chk("lz_hex", int'(dig), int'(pk(23, 23, 10, 0)));

        out_mux_sel = 3'd4; cyc(); chk("zeros", int'(dig), 0);
        out_mux_sel = 3'd6; cyc(); chk("err", int'(dig), int'(pk(23, 14, 28, 28)));

        out_mux_sel = 3'd7; tick = 1'b1;
        cyc();
        chk("test_first", int'(dig), int'(pk(16, 16, 16, 16)));
        cyc(3);
        chk("test_segb", int'(dig), int'(pk(17, 17, 17, 17)));
        cyc(10);
        chk("test_segg", int'(dig), int'(pk(22, 22, 22, 22)));
        cyc(2);
        chk("test_wrap", int'(dig), int'(pk(16, 16, 16, 16)));
        cyc(2);
        chk("test_mid", int'(dig), int'(pk(17, 17, 17, 17)));

        reset = 1'b1;
        cyc();
        chk("midtest_reset", int'(dig), int'(pk(23, 23, 23, 23)));
        chk("midtest_reset_phase", int'(blink_phase), 0);
        reset = 1'b0;
        cyc();
        chk("reentry_first", int'(dig), int'(pk(16, 16, 16, 16)));
        cyc(3);
        chk("reentry_segb", int'(dig), int'(pk(17, 17, 17, 17)));

        tick = 1'b0;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
